// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring shift-subtract, one quotient bit per cycle.
// Latency WIDTH+2 cycles (1 for divide-by-zero/overflow); stall on o_busy, no backpressure.

module carry_4 (
    input  logic       ci,
    input  logic       cyinit,
    input  logic [3:0] di,
    input  logic [3:0] s,
    output logic [3:0] o,
    output logic [3:0] co
);
    logic [4:0] c;

    always_comb begin
        c[0] = ci | cyinit;
        for (int i = 0; i < 4; i++) begin
            o[i]     = s[i] ^ c[i];
            c[i + 1] = s[i] ? c[i] : di[i];
        end
        co = c[4:1];
    end
endmodule

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_kill,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int NS = WIDTH / 4 + 1;
    localparam int NB = 4 * NS;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Subtractor: t - {0,divisor} over a chain of carry_4 slices
    logic [WIDTH:0] t;
    logic [NB-1:0]  t_pad, d_pad, s_pad, o_pad, co_pad;
    logic [NS:0]    chain;
    logic           no_borrow;

    assign t      = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign t_pad  = NB'(t);
    assign d_pad  = NB'({1'b0, dvs_q});
    assign s_pad  = t_pad ^ ~d_pad;
    assign chain[0] = 1'b0;

    for (genvar g = 0; g < NS; g++) begin : g_slice
        carry_4 u_c4 (
            .ci     (chain[g]),
            .cyinit (g == 0),
            .di     (t_pad[4*g +: 4]),
            .s      (s_pad[4*g +: 4]),
            .o      (o_pad[4*g +: 4]),
            .co     (co_pad[4*g +: 4])
        );
        assign chain[g + 1] = co_pad[4*g + 3];
    end

    assign no_borrow = co_pad[WIDTH];

    // Restoring division keeps rem below the divisor, so its top bit never feeds back
    logic unused_bits;
    assign unused_bits = ^{o_pad[NB-1:WIDTH+1], co_pad, chain[NS], rem_q[WIDTH]};

    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        sgn      = ~i_op[0];
        a_neg    = sgn & i_dividend[WIDTH-1];
        b_neg    = sgn & i_divisor[WIDTH-1];
        a_abs    = a_neg ? -i_dividend : i_dividend;
        b_abs    = b_neg ? -i_divisor : i_divisor;
        q_fix    = (qneg_q && !op_q[0]) ? -quo_q : quo_q;
        r_fix    = (rneg_q && !op_q[0]) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        if (i_kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (i_start) begin
                        op_d   = i_op;
                        qneg_d = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        if (i_divisor == '0) begin
                            result_d = i_op[1] ? i_dividend : '1;
                            state_d  = S_DONE;
                        end else if (sgn && i_dividend == MIN_NEG && i_divisor == '1) begin
                            result_d = i_op[1] ? '0 : MIN_NEG;
                            state_d  = S_DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_abs;
                            dvs_d   = b_abs;
                            cnt_d   = CW'(WIDTH - 1);
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_d = no_borrow ? o_pad[WIDTH:0] : t;
                    quo_d = {quo_q[WIDTH-2:0], no_borrow};
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_FIX: begin
                    result_d = op_q[1] ? r_fix : q_fix;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign o_busy   = (state_q == S_RUN) || (state_q == S_FIX);
    assign o_done   = (state_q == S_DONE);
    assign o_result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against an arithmetic reference model.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        i_kill = 1'b0;
    logic        o_busy, o_done;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_kill     (i_kill),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic issue_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int lat, output int bcnt, output logic [31:0] res,
                              output logic got);
        i_start = 1'b1; i_op = op; i_dividend = a; i_divisor = b;
        @(negedge clk);
        i_start = 1'b0;
        lat = 1; bcnt = 0; got = 1'b0; res = 'x;
        while (lat <= 40) begin
            if (o_busy) bcnt++;
            if (o_done) begin
                got = 1'b1;
                res = o_result;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output int bcnt);
        logic [31:0] res;
        logic        got;
        issue_wait(op, a, b, lat, bcnt, res, got);
        chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_result"}, res, model(op, a, b));
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [31:0] res, a, b;
        logic        got;
        logic [1:0]  op;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        run("divu_100_7", 2'b01, 32'd100, 32'd7, lat, bcnt);
        chk("divu_latency", lat, 34);
        chk("divu_busy_cycles", bcnt, 33);
        run("remu_100_7", 2'b11, 32'd100, 32'd7, lat, bcnt);
        chk("remu_value", model(2'b11, 32'd100, 32'd7), 32'd2);
        run("div_m7_2", 2'b00, -32'sd7, 32'd2, lat, bcnt);
        run("rem_m7_2", 2'b10, -32'sd7, 32'd2, lat, bcnt);
        run("rem_7_m2", 2'b10, 32'd7, -32'sd2, lat, bcnt);
        run("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
        chk("div_m7_2_abs", model(2'b00, -32'sd7, 32'd2), 32'hFFFF_FFFD);

        run("div_5_0", 2'b00, 32'd5, 32'd0, lat, bcnt);
        chk("div0_latency", lat, 1);
        chk("div0_busy", bcnt, 0);
        run("remu_5_0", 2'b11, 32'd5, 32'd0, lat, bcnt);
        run("rem_m5_0", 2'b10, -32'sd5, 32'd0, lat, bcnt);
        chk("rem_m5_0_busy", bcnt, 0);
        run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("ovf_latency", lat, 1);
        chk("ovf_busy", bcnt, 0);
        run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        run("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("divu_min_m1_latency", lat, 34);

        // Kill mid-run: cycles counted from the accept edge
        i_start = 1'b1; i_op = 2'b01; i_dividend = 32'd1000000; i_divisor = 32'd3;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        i_kill = 1'b1;
        @(negedge clk);
        i_kill = 1'b0;
        chk("kill_busy", {31'd0, o_busy}, 32'd0);
        chk("kill_done", {31'd0, o_done}, 32'd0);
        ndone = 0;
        repeat (40) begin
            if (o_done) ndone++;
            @(negedge clk);
        end
        chk("kill_no_done", ndone, 0);
        run("divu_9_3", 2'b01, 32'd9, 32'd3, lat, bcnt);
        chk("after_kill_latency", lat, 34);

        // Reset mid-run
        i_start = 1'b1; i_op = 2'b00; i_dividend = 32'd65535; i_divisor = 32'd3;
        @(negedge clk);
        i_start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        chk("mid_rst_result", o_result, 32'd0);
        i_rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            if (o_done) ndone++;
            @(negedge clk);
        end
        chk("rst_no_done", ndone, 0);

        // Back-to-back: second start in the first op's DONE cycle
        issue_wait(2'b01, 32'd1000, 32'd10, lat, bcnt, res, got);
        chk("b2b_first_seen", {31'd0, got}, 32'd1);
        chk("b2b_first", res, 32'd100);
        issue_wait(2'b10, -32'sd100, 32'd7, lat, bcnt, res, got);
        chk("b2b_second_seen", {31'd0, got}, 32'd1);
        chk("b2b_second", res, 32'hFFFF_FFFE);
        chk("b2b_latency", lat, 34);
        @(negedge clk);

        for (int i = 0; i < 1500; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 255));
                5: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            run("random", op, a, b, lat, bcnt);
            chk("random_latency", lat, (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
